// File: rtl/cpu_divider.sv
// Multi-cycle restoring integer divider for DIVU/DIVS/MODU/MODS beside the ALU.
// Resolves UNROLL quotient bits per cycle, then applies a one-cycle sign fixup.
module cpu_divider #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             p3_start,
    input  logic [1:0]       p3_mode,
    input  logic [WIDTH-1:0] p3_data_a,
    input  logic [WIDTH-1:0] p3_data_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int N     = WIDTH / UNROLL;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_q_q, sign_q_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               accept;
    logic               is_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               div_by_zero, overflow, fast;
    logic [WIDTH-1:0]   fast_result;
    logic [WIDTH:0]     rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_result;

    // Operand decode for the accept cycle
    always_comb begin
        accept      = p3_start && (state_q == S_IDLE) && !flush;
        is_signed   = p3_mode[0];
        a_neg       = is_signed && p3_data_a[WIDTH-1];
        b_neg       = is_signed && p3_data_b[WIDTH-1];
        a_mag       = a_neg ? -p3_data_a : p3_data_a;
        b_mag       = b_neg ? -p3_data_b : p3_data_b;
        div_by_zero = (p3_data_b == '0);
        overflow    = is_signed && (p3_data_a == MIN_INT) && (p3_data_b == ALL_ONES);
        fast        = div_by_zero || overflow;
        if (div_by_zero) begin
            fast_result = p3_mode[1] ? p3_data_a : ALL_ONES;
        end else begin
            fast_result = p3_mode[1] ? '0 : MIN_INT;
        end
    end

    // UNROLL restoring steps: quo_q holds the not-yet-consumed dividend bits
    // at the top and the freshly produced quotient bits at the bottom.
    always_comb begin
        rem_step = rem_q;
        quo_step = quo_q;
        for (int i = 0; i < UNROLL; i++) begin
            rem_step = {rem_step[WIDTH-1:0], quo_step[WIDTH-1]};
            quo_step = {quo_step[WIDTH-2:0], 1'b0};
            if (rem_step >= {1'b0, div_q}) begin
                rem_step    = rem_step - {1'b0, div_q};
                quo_step[0] = 1'b1;
            end
        end
    end

    always_comb begin
        quo_fix    = sign_q_q ? -quo_q : quo_q;
        rem_fix    = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        fix_result = mode_q[1] ? rem_fix : quo_fix;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && !fast) state_d = S_RUN;
            S_RUN:   if (cnt_q == CNT_LAST) state_d = S_FIXUP;
            S_FIXUP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = done_q;
        result = result_q;
    end

    always_comb begin
        mode_d   = mode_q;
        sign_a_d = sign_a_q;
        sign_q_d = sign_q_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        if (accept) begin
            mode_d   = p3_mode;
            sign_a_d = a_neg;
            sign_q_d = a_neg ^ b_neg;
            rem_d    = '0;
            quo_d    = a_mag;
            div_d    = b_mag;
            cnt_d    = '0;
            if (fast) begin
                result_d = fast_result;
                done_d   = 1'b1;
            end
        end else if (state_q == S_RUN) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + CNT_ONE;
        end else if (state_q == S_FIXUP) begin
            result_d = fix_result;
            done_d   = 1'b1;
        end
        // A flush wins over everything, including a completion on this edge.
        if (flush) begin
            done_d   = 1'b0;
            result_d = result_q;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q   <= '0;
            sign_a_q <= 1'b0;
            sign_q_q <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            mode_q   <= mode_d;
            sign_a_q <= sign_a_d;
            sign_q_q <= sign_q_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

endmodule
